// File: rtl/axis_pkg.sv
// axis_pkg: shared stream FSM state enum and lane-width constant
package axis_pkg;
  localparam int LANE_W = 32;
  typedef enum logic [1:0] {IDLE, SEND, GAP, FIN} state_t;
endpackage

// File: rtl/axis_lane_pattern.sv
// axis_lane_pattern: combinational payload, 32-bit lane i = beat_ctr ^ i (in beat_ctr, out data)
module axis_lane_pattern import axis_pkg::*; #(
  parameter int WIDTH = 128
) (
  input  logic [LANE_W-1:0] beat_ctr,
  output logic [WIDTH-1:0]  data
);
  for (genvar g = 0; g < WIDTH / LANE_W; g++) begin : g_lane
    assign data[g*LANE_W +: LANE_W] = beat_ctr ^ LANE_W'(g);
  end
endmodule

// File: rtl/axis_pkt_gen_v1.sv
// axis_pkt_gen_v1: AXI-Stream packet generator; start/config in, master_* stream out, busy/done/beats_sent status
module axis_pkt_gen_v1 import axis_pkg::*; #(
  parameter int WIDTH = 128,
  parameter int LEN_W = 16
) (
  input  logic             aclk,
  input  logic             areset,
  input  logic             start,
  input  logic [LEN_W-1:0] pkt_len,
  input  logic [LEN_W-1:0] num_pkts,
  input  logic [LEN_W-1:0] gap,
  input  logic [31:0]      seed,
  output logic [WIDTH-1:0] master_tdata,
  output logic             master_tvalid,
  input  logic             master_tready,
  output logic             master_tlast,
  output logic             busy,
  output logic             done,
  output logic [31:0]      beats_sent
);
  state_t state, state_nx;
  logic [LEN_W-1:0] len_m1, beat_idx, pkts_left, gap_r, gap_cnt;
  logic [31:0] beat_ctr;
  logic [WIDTH-1:0] pattern;
  logic hs, last_beat, accept;
  axis_lane_pattern #(.WIDTH(WIDTH)) u_pat (.beat_ctr(beat_ctr), .data(pattern));
  assign accept = state == IDLE && start;
  assign master_tvalid = state == SEND;
  assign hs = master_tvalid && master_tready;
  assign last_beat = beat_idx == len_m1;
  assign master_tlast = master_tvalid && last_beat;
  assign master_tdata = master_tvalid ? pattern : '0;
  assign busy = state == SEND || state == GAP;
  assign done = state == FIN;
  always_comb begin
    state_nx = state;
    state_nx = state == IDLE ? (start ? (num_pkts == '0 ? FIN : SEND) : IDLE)
             : state == SEND ? (hs && last_beat ? (pkts_left == LEN_W'(1) ? FIN : gap_r != '0 ? GAP : SEND) : SEND)
             : state == GAP  ? (gap_cnt == '0 ? SEND : GAP)
             : IDLE;
  end
  always_ff @(posedge aclk or posedge areset)
    if (areset) state <= IDLE;
    else state <= state_nx;
  always_ff @(posedge aclk or posedge areset)
    if (areset) begin
      len_m1     <= '0;
      beat_idx   <= '0;
      pkts_left  <= '0;
      gap_r      <= '0;
      gap_cnt    <= '0;
      beat_ctr   <= '0;
      beats_sent <= '0;
    end else begin
      if (accept) begin
        len_m1     <= pkt_len == '0 ? '0 : pkt_len - LEN_W'(1);
        pkts_left  <= num_pkts;
        gap_r      <= gap;
        beat_ctr   <= seed;
        beats_sent <= '0;
        beat_idx   <= '0;
      end
      if (hs) begin
        beat_ctr   <= beat_ctr + 32'd1;
        beats_sent <= beats_sent + 32'd1;
        beat_idx   <= last_beat ? '0 : beat_idx + LEN_W'(1);
        if (last_beat) begin
          pkts_left <= pkts_left - LEN_W'(1);
          gap_cnt   <= gap_r - LEN_W'(1);
        end
      end
      if (state == GAP) gap_cnt <= gap_cnt - LEN_W'(1);
    end
endmodule

// File: tb/tb_axis_pkt_gen_v1.sv
// tb_axis_pkt_gen_v1: directed self-checking bench for axis_pkt_gen_v1
module tb_axis_pkt_gen_v1;
  logic aclk, areset, start, master_tvalid, master_tready, master_tlast, busy, done;
  logic [15:0] pkt_len, num_pkts, gap;
  logic [31:0] seed, beats_sent;
  logic [127:0] master_tdata;
  int n_assert = 0;
  int n_fail = 0;
  axis_pkt_gen_v1 #(.WIDTH(128), .LEN_W(16)) dut (
    .aclk(aclk), .areset(areset), .start(start), .pkt_len(pkt_len), .num_pkts(num_pkts),
    .gap(gap), .seed(seed), .master_tdata(master_tdata), .master_tvalid(master_tvalid),
    .master_tready(master_tready), .master_tlast(master_tlast), .busy(busy), .done(done),
    .beats_sent(beats_sent)
  );
  initial aclk = 0;
  always #5 aclk = ~aclk;
  function automatic logic [127:0] pat(logic [31:0] c);
    return {c ^ 32'd3, c ^ 32'd2, c ^ 32'd1, c};
  endfunction
  task automatic chk(string tag, logic [127:0] obs, logic [127:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic tick;
    @(posedge aclk);
    #1;
  endtask
  task automatic beat(string tag, logic [31:0] c, logic last);
    chk({tag, "_tvalid"}, 128'(master_tvalid), 128'(1));
    chk({tag, "_tdata"}, master_tdata, pat(c));
    chk({tag, "_tlast"}, 128'(master_tlast), 128'(last));
    chk({tag, "_busy"}, 128'(busy), 128'(1));
    tick;
  endtask
  task automatic go(logic [31:0] s, logic [15:0] l, logic [15:0] n, logic [15:0] g);
    seed = s; pkt_len = l; num_pkts = n; gap = g; start = 1;
    tick;
    start = 0;
  endtask
  task automatic fin(string tag, logic [31:0] cnt);
    chk({tag, "_done"}, 128'(done), 128'(1));
    chk({tag, "_busy_low"}, 128'(busy), 128'(0));
    chk({tag, "_tvalid_low"}, 128'(master_tvalid), 128'(0));
    chk({tag, "_beats_sent"}, 128'(beats_sent), 128'(cnt));
    tick;
    chk({tag, "_done_1cyc"}, 128'(done), 128'(0));
  endtask
  initial begin
    areset = 1; start = 0; master_tready = 1; seed = 0; pkt_len = 0; num_pkts = 0; gap = 0;
    #3;
    chk("rst_async_tvalid", 128'(master_tvalid), 128'(0));
    chk("rst_async_tdata", master_tdata, 128'(0));
    chk("rst_async_busy", 128'(busy), 128'(0));
    chk("rst_async_done", 128'(done), 128'(0));
    chk("rst_async_beats", 128'(beats_sent), 128'(0));
    tick; tick;
    areset = 0;
    tick;
    chk("idle_tvalid", 128'(master_tvalid), 128'(0));
    chk("idle_tlast", 128'(master_tlast), 128'(0));
    // single packet of 4 back-to-back beats
    go(32'h10, 4, 1, 0);
    for (int k = 0; k < 4; k++) beat("a", 32'h10 + k, k == 3);
    fin("a", 4);
    // two packets of 3 with a 2-cycle gap
    go(32'h100, 3, 2, 2);
    for (int k = 0; k < 3; k++) beat("b1", 32'h100 + k, k == 2);
    for (int k = 0; k < 2; k++) begin
      chk("b_gap_tvalid", 128'(master_tvalid), 128'(0));
      chk("b_gap_busy", 128'(busy), 128'(1));
      tick;
    end
    for (int k = 0; k < 3; k++) beat("b2", 32'h103 + k, k == 2);
    fin("b", 6);
    // 5-cycle back-pressure on the second beat
    go(32'h200, 4, 1, 0);
    beat("c0", 32'h200, 0);
    master_tready = 0;
    for (int k = 0; k < 5; k++) beat("c_stall", 32'h201, 0);
    master_tready = 1;
    for (int k = 1; k < 4; k++) beat("c", 32'h200 + k, k == 3);
    fin("c", 4);
    // counter wrap
    go(32'hFFFF_FFFE, 3, 1, 0);
    chk("d_lane3", 128'(master_tdata[127:96]), 128'(32'hFFFF_FFFD));
    beat("d0", 32'hFFFF_FFFE, 0);
    beat("d1", 32'hFFFF_FFFF, 0);
    chk("d2_lane0", 128'(master_tdata[31:0]), 128'(0));
    beat("d2", 32'h0, 1);
    fin("d", 3);
    // zero packets
    go(32'h5, 4, 0, 0);
    fin("e", 0);
    // zero length packets, plus an ignored start mid-run
    go(32'h300, 0, 2, 0);
    seed = 32'h999; pkt_len = 5; num_pkts = 7; start = 1;
    beat("f0", 32'h300, 1);
    start = 0;
    beat("f1", 32'h301, 1);
    fin("f", 2);
    // reset mid-run, then fresh run from seed 0
    go(32'h400, 8, 1, 0);
    beat("g0", 32'h400, 0);
    chk("g_pre_rst_beats", 128'(beats_sent), 128'(1));
    areset = 1;
    #1;
    chk("g_rst_tvalid", 128'(master_tvalid), 128'(0));
    chk("g_rst_tdata", master_tdata, 128'(0));
    chk("g_rst_beats", 128'(beats_sent), 128'(0));
    chk("g_rst_busy", 128'(busy), 128'(0));
    tick;
    areset = 0;
    tick;
    chk("g_post_rst_tvalid", 128'(master_tvalid), 128'(0));
    go(32'h0, 8, 1, 0);
    chk("g_new_beats", 128'(beats_sent), 128'(0));
    for (int k = 0; k < 8; k++) beat("g", k, k == 7);
    fin("g", 8);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
